// File: rtl/tcam_lookup_sched.sv
// Shares one TCAM port between NUM_REQ lookup requesters, a config-write port and a flush port.
// One operation in flight; each compare result is returned, tagged, to the requester that issued it.
module tcam_lookup_sched #(
  parameter int unsigned ID_Width    = 4,
  parameter int unsigned AddressSize = 4,
  parameter int unsigned Bits        = 8,
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned CMP_LAT     = 3,
  localparam int unsigned TagW       = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ID_Width-1:0]  req_id,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rsp_valid,
  output logic [TagW-1:0]              rsp_tag,
  output logic [ID_Width-1:0]          rsp_dst_id,
  input  logic                         cfg_wr_valid,
  output logic                         cfg_wr_ready,
  input  logic [AddressSize-1:0]       cfg_addr,
  input  logic [Bits-1:0]              cfg_data,
  input  logic [Bits-1:0]              cfg_mskb,
  input  logic                         cfg_vbe,
  input  logic                         cfg_dcs,
  input  logic                         cfg_vbi,
  input  logic                         flush_valid,
  output logic                         flush_ready,
  output logic                         busy,
  output logic [2:0]                   mem_mode,
  output logic [ID_Width-1:0]          mem_packet_id,
  output logic [AddressSize-1:0]       mem_a,
  output logic [Bits-1:0]              mem_data,
  output logic [Bits-1:0]              mem_mskb,
  output logic                         mem_vbe,
  output logic                         mem_dcs,
  output logic                         mem_vbi,
  input  logic [ID_Width-1:0]          mem_dst_id
);

  localparam int unsigned CntW = $clog2(CMP_LAT + 1);

  localparam logic [2:0] ModeIdle  = 3'b000;
  localparam logic [2:0] ModeWrite = 3'b001;
  localparam logic [2:0] ModeFlush = 3'b011;
  localparam logic [2:0] ModeCmp   = 3'b100;

  typedef enum logic [2:0] {StIdle, StIssue, StGap, StWait, StResp} state_e;

  state_e                 state_q, state_d;
  logic [TagW-1:0]        rr_q, rr_d;
  logic [TagW-1:0]        tag_q, tag_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             mode_q, mode_d;
  logic [ID_Width-1:0]    pid_q, pid_d;
  logic [AddressSize-1:0] addr_q, addr_d;
  logic [Bits-1:0]        data_q, data_d;
  logic [Bits-1:0]        mskb_q, mskb_d;
  logic                   vbe_q, vbe_d, dcs_q, dcs_d, vbi_q, vbi_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [TagW-1:0]        rsp_tag_q, rsp_tag_d;
  logic [ID_Width-1:0]    rsp_dst_q, rsp_dst_d;

  logic                   grant_found;
  logic [TagW-1:0]        grant_idx;
  logic [TagW-1:0]        rr_next;
  logic [ID_Width-1:0]    grant_id;

  // Round-robin search starting at rr_q, then fixed flush > write > lookup priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_found && req_valid[TagW'((32'(rr_q) + i) % NUM_REQ)]) begin
        grant_found = 1'b1;
        grant_idx   = TagW'((32'(rr_q) + i) % NUM_REQ);
      end
    end
    grant_id = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == TagW'(i)) grant_id = req_id[i*ID_Width +: ID_Width];
    end
    rr_next = TagW'((32'(grant_idx) + 32'd1) % NUM_REQ);

    flush_ready  = 1'b0;
    cfg_wr_ready = 1'b0;
    req_ready    = '0;
    if (rst_n && (state_q == StIdle)) begin
      if (flush_valid) begin
        flush_ready = 1'b1;
      end else if (cfg_wr_valid) begin
        cfg_wr_ready = 1'b1;
      end else if (grant_found) begin
        req_ready[grant_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    mode_d      = ModeIdle;
    pid_d       = pid_q;
    addr_d      = addr_q;
    data_d      = data_q;
    mskb_d      = mskb_q;
    vbe_d       = vbe_q;
    dcs_d       = dcs_q;
    vbi_d       = vbi_q;
    rsp_valid_d = 1'b0;
    rsp_tag_d   = rsp_tag_q;
    rsp_dst_d   = rsp_dst_q;
    unique case (state_q)
      StIdle: begin
        if (flush_ready) begin
          mode_d  = ModeFlush;
          state_d = StIssue;
        end else if (cfg_wr_ready) begin
          mode_d  = ModeWrite;
          addr_d  = cfg_addr;
          data_d  = cfg_data;
          mskb_d  = cfg_mskb;
          vbe_d   = cfg_vbe;
          dcs_d   = cfg_dcs;
          vbi_d   = cfg_vbi;
          state_d = StIssue;
        end else if (|req_ready) begin
          mode_d  = ModeCmp;
          pid_d   = grant_id;
          tag_d   = grant_idx;
          rr_d    = rr_next;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (mode_q == ModeCmp) begin
          cnt_d   = CntW'(1);
          state_d = StWait;
        end else begin
          state_d = StGap;
        end
      end
      StGap: state_d = StIdle;
      // StResp is the cycle in which mem_dst_id is valid, CMP_LAT cycles after issue.
      StWait: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(CMP_LAT - 1)) state_d = StResp;
      end
      StResp: begin
        rsp_valid_d = 1'b1;
        rsp_tag_d   = tag_q;
        rsp_dst_d   = mem_dst_id;
        cnt_d       = '0;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      tag_q       <= '0;
      cnt_q       <= '0;
      mode_q      <= ModeIdle;
      pid_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      mskb_q      <= '0;
      vbe_q       <= 1'b0;
      dcs_q       <= 1'b0;
      vbi_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_tag_q   <= '0;
      rsp_dst_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      pid_q       <= pid_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      mskb_q      <= mskb_d;
      vbe_q       <= vbe_d;
      dcs_q       <= dcs_d;
      vbi_q       <= vbi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_dst_q   <= rsp_dst_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign mem_mode      = mode_q;
  assign mem_packet_id = pid_q;
  assign mem_a         = addr_q;
  assign mem_data      = data_q;
  assign mem_mskb      = mskb_q;
  assign mem_vbe       = vbe_q;
  assign mem_dcs       = dcs_q;
  assign mem_vbi       = vbi_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_tag       = rsp_tag_q;
  assign rsp_dst_id    = rsp_dst_q;

endmodule
